vote_capture_ack: RTL and testbench

Captures voter push-button presses, debounces them, and latches a single vote. The latched vote is presented to the Nios II CPU as an Avalon-MM slave with an interrupt. The block sits directly downstream of the CPU's single-bit VotingACK PIO output and consumes it as `vote_ack`. The block holds each vote until the CPU acknowledges it through that PIO, then re-arms once the ack and all buttons are released (four-phase handshake).

---
 rtl/vote_capture_ack.sv | 214 +++++++++++++++++++++
 tb/tb_vote_capture_ack.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vote_capture_ack.sv
`default_nettype none
// ============================================================================
//  Module   : vote_capture_ack
//  Purpose  : Debounces voter push-buttons and latches one vote at a time.
//             The vote is held for the CPU, which reads it over an Avalon-MM
//             slave and is signalled through an interrupt. Each vote is
//             released by a four-phase handshake on vote_ack from the CPU.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk         system clock
//    reset_n     synchronous active-low reset
//    vote_btn    raw buttons, active-high, asynchronous to clk
//    vote_ack    ack level from the CPU PIO, already synchronous to clk
//    address     Avalon word address (0 VOTE, 1 TOTAL, 2 REJECT, 3 CTRL)
//    chipselect  slave select
//    write_n     active-low write strobe
//    writedata   write data
//    readdata    read data, combinational on address
//    vote_valid  vote latched and waiting for the ack
//    irq         vote_valid gated by the interrupt enable
// ============================================================================
module vote_capture_ack #(
    parameter int NUM_CHOICES     = 4,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [NUM_CHOICES-1:0] vote_btn,
    input  logic                   vote_ack,
    input  logic [1:0]             address,
    input  logic                   chipselect,
    input  logic                   write_n,
    input  logic [31:0]            writedata,
    output logic [31:0]            readdata,
    output logic                   vote_valid,
    output logic                   irq
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_DEBOUNCE = 2'd1,
        S_PENDING  = 2'd2,
        S_RELEASE  = 2'd3
    } state_t;

    state_t                 r_state;
    state_t                 w_next_state;
    logic [NUM_CHOICES-1:0] r_btn_meta;
    logic [NUM_CHOICES-1:0] r_btn_s;
    logic [NUM_CHOICES-1:0] r_cand;
    logic [CNT_W-1:0]       r_cnt;
    logic [2:0]             r_vote_idx;
    logic [15:0]            r_total;
    logic [15:0]            r_reject;
    logic                   r_irq_en;
    logic                   r_multi_q;

    logic       w_onehot;
    logic       w_multi;
    logic [3:0] w_pop;
    logic [2:0] w_cand_idx;
    logic       w_load_cand;
    logic       w_inc_cnt;
    logic       w_latch_vote;
    logic       w_wr;
    logic       w_clear;
    logic       w_unused_wd;

    // Two-flop synchronizer for the asynchronous buttons.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_btn_meta <= '0;
            r_btn_s    <= '0;
        end else begin
            r_btn_meta <= vote_btn;
            r_btn_s    <= r_btn_meta;
        end
    end

    always_comb begin
        w_pop = 4'd0;
        for (int i = 0; i < NUM_CHOICES; i++) begin
            w_pop = w_pop + 4'(r_btn_s[i]);
        end
    end

    assign w_onehot = (w_pop == 4'd1);
    assign w_multi  = (w_pop >= 4'd2);

    always_comb begin
        w_cand_idx = 3'd0;
        for (int i = 0; i < NUM_CHOICES; i++) begin
            if (r_cand[i]) begin
                w_cand_idx = 3'(i);
            end
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and datapath control.
    always_comb begin
        w_next_state = r_state;
        w_load_cand  = 1'b0;
        w_inc_cnt    = 1'b0;
        w_latch_vote = 1'b0;
        case (r_state)
            S_IDLE: begin
                // A stale ack from the previous vote blocks a new capture.
                if (w_onehot && !vote_ack) begin
                    w_load_cand  = 1'b1;
                    w_next_state = S_DEBOUNCE;
                end
            end
            S_DEBOUNCE: begin
                if (r_btn_s != r_cand) begin
                    w_next_state = S_IDLE;
                end else if (r_cnt == C_CNT_LAST) begin
                    w_latch_vote = 1'b1;
                    w_next_state = S_PENDING;
                end else begin
                    w_inc_cnt = 1'b1;
                end
            end
            S_PENDING: begin
                if (vote_ack) begin
                    w_next_state = S_RELEASE;
                end
            end
            S_RELEASE: begin
                if (!vote_ack && (r_btn_s == '0)) begin
                    w_next_state = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    assign w_wr    = chipselect & ~write_n;
    assign w_clear = w_wr && (address == 2'd3) && writedata[1];

    // Only CTRL bits [1:0] are writable.
    assign w_unused_wd = &{1'b0, writedata[31:2]};

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_cand     <= '0;
            r_cnt      <= '0;
            r_vote_idx <= 3'd0;
            r_total    <= 16'd0;
            r_reject   <= 16'd0;
            r_irq_en   <= 1'b0;
            r_multi_q  <= 1'b0;
        end else begin
            r_multi_q <= w_multi;

            if (w_load_cand) begin
                r_cand <= r_btn_s;
                r_cnt  <= '0;
            end else if (w_inc_cnt) begin
                r_cnt <= r_cnt + 1'b1;
            end

            if (w_latch_vote) begin
                r_vote_idx <= w_cand_idx;
            end

            // Clear has priority over a same-cycle increment.
            if (w_clear) begin
                r_total <= 16'd0;
            end else if (w_latch_vote) begin
                r_total <= r_total + 16'd1;
            end

            // Count each new multi-press once, only while a vote can be captured.
            if (w_clear) begin
                r_reject <= 16'd0;
            end else if (((r_state == S_IDLE) || (r_state == S_DEBOUNCE)) &&
                         w_multi && !r_multi_q && (r_reject != 16'hFFFF)) begin
                r_reject <= r_reject + 16'd1;
            end

            if (w_wr && (address == 2'd3)) begin
                r_irq_en <= writedata[0];
            end
        end
    end

    assign vote_valid = (r_state == S_PENDING);
    assign irq        = vote_valid & r_irq_en;

    always_comb begin
        readdata = 32'd0;
        case (address)
            2'd0:    readdata = {vote_valid, 28'd0, r_vote_idx};
            2'd1:    readdata = {16'd0, r_total};
            2'd2:    readdata = {16'd0, r_reject};
            default: readdata = {31'd0, r_irq_en};
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_vote_capture_ack.sv
`default_nettype none
// ============================================================================
//  Module   : tb_vote_capture_ack
//  Purpose  : Self-checking bench for vote_capture_ack with a short debounce.
//             Expected VOTE register values are queued when a press is driven
//             and compared when the DUT raises vote_valid.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_vote_capture_ack;

    localparam int NUM_CHOICES     = 4;
    localparam int DEBOUNCE_CYCLES = 4;

    logic                   clk = 1'b0;
    logic                   reset_n;
    logic [NUM_CHOICES-1:0] vote_btn;
    logic                   vote_ack;
    logic [1:0]             address;
    logic                   chipselect;
    logic                   write_n;
    logic [31:0]            writedata;
    logic [31:0]            readdata;
    logic                   vote_valid;
    logic                   irq;

    int          n_assert = 0;
    int          n_fail   = 0;
    logic [31:0] sb_q[$];
    logic        seen;

    vote_capture_ack #(
        .NUM_CHOICES    (NUM_CHOICES),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .vote_btn  (vote_btn),
        .vote_ack  (vote_ack),
        .address   (address),
        .chipselect(chipselect),
        .write_n   (write_n),
        .writedata (writedata),
        .readdata  (readdata),
        .vote_valid(vote_valid),
        .irq       (irq)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic check_rd(input string tag, input logic [1:0] a, input logic [31:0] exp);
        address    = a;
        chipselect = 1'b1;
        write_n    = 1'b1;
        #1;
        check(tag, readdata, exp);
        chipselect = 1'b0;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        chipselect = 1'b1;
        write_n    = 1'b0;
        writedata  = d;
        tick();
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = 32'd0;
    endtask

    // Bounded wait for a vote, then compare VOTE against the scoreboard.
    task automatic wait_vote(input int budget, input string tag);
        int          k;
        logic [31:0] exp;
        k = 0;
        while (!vote_valid && k < budget) begin
            tick();
            k++;
        end
        check({tag, "_valid"}, 32'(vote_valid), 32'd1);
        exp = (sb_q.size() > 0) ? sb_q.pop_front() : 32'hDEAD_BEEF;
        check_rd({tag, "_vote"}, 2'd0, exp);
    endtask

    // Run n cycles, noting whether vote_valid was ever high.
    task automatic idle_watch(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            seen = seen | vote_valid;
        end
    endtask

    task automatic ack_release(input string tag);
        vote_ack = 1'b1;
        tick();
        check({tag, "_ack_drop"}, 32'(vote_valid), 32'd0);
        vote_ack = 1'b0;
        vote_btn = '0;
        repeat (4) tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n    = 1'b0;
        vote_btn   = '0;
        vote_ack   = 1'b0;
        address    = 2'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = 32'd0;
        seen       = 1'b0;

        // Reset
        repeat (2) tick();
        reset_n = 1'b1;
        check_rd("rst_vote", 2'd0, 32'h0);
        check_rd("rst_total", 2'd1, 32'h0);
        check_rd("rst_reject", 2'd2, 32'h0);
        check_rd("rst_ctrl", 2'd3, 32'h0);
        check("rst_valid", 32'(vote_valid), 32'd0);
        check("rst_irq", 32'(irq), 32'd0);

        // Clean press: vote_valid rises 7 edges after the button
        wr(2'd3, 32'h1);
        check_rd("ctrl_rb", 2'd3, 32'h1);
        sb_q.push_back(32'h8000_0002);
        vote_btn = 4'b0100;
        repeat (6) tick();
        check("clean_early", 32'(vote_valid), 32'd0);
        tick();
        check("clean_valid", 32'(vote_valid), 32'd1);
        check("clean_irq", 32'(irq), 32'd1);
        check_rd("clean_vote", 2'd0, sb_q.pop_front());
        check_rd("clean_total", 2'd1, 32'd1);
        vote_ack = 1'b1;
        tick();
        check("clean_ack_drop", 32'(vote_valid), 32'd0);
        check("clean_irq_drop", 32'(irq), 32'd0);
        vote_ack = 1'b0;
        vote_btn = '0;
        repeat (4) tick();

        // Bounce: clear counters first, keep irq enabled
        wr(2'd3, 32'h3);
        check_rd("bounce_total0", 2'd1, 32'd0);
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            vote_btn = 4'b0001;
            idle_watch(2);
            vote_btn = 4'b0000;
            idle_watch(2);
        end
        check("bounce_no_vote", 32'(seen), 32'd0);
        sb_q.push_back(32'h8000_0000);
        vote_btn = 4'b0001;
        wait_vote(10, "bounce");
        check_rd("bounce_total", 2'd1, 32'd1);
        ack_release("bounce");

        // Multi-press: counted as rejects, never a vote
        seen = 1'b0;
        for (int r = 0; r < 3; r++) begin
            vote_btn = 4'b0011;
            idle_watch(10);
            vote_btn = 4'b0000;
            idle_watch(4);
            if (r == 0) check_rd("multi_reject1", 2'd2, 32'd1);
        end
        check("multi_no_vote", 32'(seen), 32'd0);
        check_rd("multi_reject3", 2'd2, 32'd3);
        check_rd("multi_total", 2'd1, 32'd1);

        // Handshake guard: stale ack blocks capture
        seen     = 1'b0;
        vote_ack = 1'b1;
        vote_btn = 4'b1000;
        idle_watch(10);
        check("guard_blocked", 32'(seen), 32'd0);
        sb_q.push_back(32'h8000_0003);
        vote_ack = 1'b0;
        wait_vote(10, "guard");
        vote_ack = 1'b1;
        tick();
        check("guard_ack_drop", 32'(vote_valid), 32'd0);
        vote_ack = 1'b0;
        seen     = 1'b0;
        idle_watch(10);
        check("guard_held_no_vote", 32'(seen), 32'd0);
        vote_btn = '0;
        repeat (4) tick();
        check_rd("guard_total", 2'd1, 32'd2);

        // Clear on the same edge the vote latches: clear wins, irq_en drops
        sb_q.push_back(32'h8000_0001);
        vote_btn = 4'b0010;
        repeat (6) tick();
        check("clr_early", 32'(vote_valid), 32'd0);
        address    = 2'd3;
        chipselect = 1'b1;
        write_n    = 1'b0;
        writedata  = 32'h2;
        tick();
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = 32'd0;
        check("clr_valid", 32'(vote_valid), 32'd1);
        check("clr_irq_off", 32'(irq), 32'd0);
        check_rd("clr_total", 2'd1, 32'd0);
        check_rd("clr_reject", 2'd2, 32'd0);
        check_rd("clr_vote", 2'd0, sb_q.pop_front());

        // Reset while PENDING discards the vote
        reset_n = 1'b0;
        tick();
        check("rstp_valid", 32'(vote_valid), 32'd0);
        check_rd("rstp_vote", 2'd0, 32'h0);
        reset_n  = 1'b1;
        vote_btn = '0;
        tick();
        check_rd("rstp_ctrl", 2'd3, 32'h0);
        check("sb_empty", 32'(sb_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
